// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
package arm_mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int DATA_BASE_DEFAULT = 1024;
  localparam int SRAM_HALF_W       = 16;
endpackage

// File: rtl/sram_wait_counter.sv
// 4-bit loadable down-counter that times each half-word SRAM access.
// Saturates at zero; load has priority over count enable.
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);
  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);
endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two held half-word accesses on a 16-bit async SRAM.
// Optional address checking is enabled by defining SRAM_ERR_CHECK_EN (adds the err port).
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int DATA_BASE     = DATA_BASE_DEFAULT,
  parameter int SRAM_ADDR_W   = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
`ifdef SRAM_ERR_CHECK_EN
  output logic                   err,
`endif
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_HALF_W-1:0] sram_dq_out,
  input  logic [SRAM_HALF_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);
  localparam int          IDX_W    = SRAM_ADDR_W - 1;
  localparam logic [31:0] BASE     = 32'(DATA_BASE);
  localparam logic [3:0]  LOAD_VAL = 4'(ACCESS_CYCLES - 1);

  mem_state_t       r_state;
  mem_state_t       w_next;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             r_is_wr;
  logic [31:0]      r_rdata;

  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_req;
  logic             w_addr_err;
  logic             w_start;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_cnt_zero;
  logic             w_unused;

  assign w_req    = rd_en | wr_en;
  assign w_off    = address - BASE;
  assign w_idx    = w_off[SRAM_ADDR_W:2];
  assign w_unused = ^{w_off[31:SRAM_ADDR_W+1], w_off[1:0]};

`ifdef SRAM_ERR_CHECK_EN
  logic r_err;

  assign w_addr_err = (address < BASE) || (address[1:0] != 2'b00) ||
                      (w_off[31:SRAM_ADDR_W+1] != '0);

  // Error requests skip the SRAM entirely; flag the single DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && w_req && w_addr_err;
    end
  end

  assign err = r_err;
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_start    = (r_state == IDLE) && w_req && !w_addr_err;
  assign w_cnt_load = w_start || ((r_state == LO) && w_cnt_zero);
  assign w_cnt_en   = (r_state == LO) || (r_state == HI);

  sram_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) w_next = w_addr_err ? DONE : LO;
      end
      LO:   if (w_cnt_zero) w_next = HI;
      HI:   if (w_cnt_zero) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_is_wr <= 1'b0;
    end else if (w_start) begin
      r_idx   <= w_idx;
      r_wdata <= write_data;
      r_is_wr <= wr_en;
    end
  end

  // Each half is captured on the last cycle its address has been held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (!r_is_wr && w_cnt_zero) begin
      if (r_state == LO) r_rdata[15:0]  <= sram_dq_in;
      if (r_state == HI) r_rdata[31:16] <= sram_dq_in;
    end
  end

  assign read_data = r_rdata;
  assign ready     = ((r_state == IDLE) && !w_req) || (r_state == DONE);

  always_comb begin
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    case (r_state)
      LO: begin
        sram_addr   = {r_idx, 1'b0};
        sram_we_n   = ~r_is_wr;
        sram_dq_oe  = r_is_wr;
        sram_dq_out = r_is_wr ? r_wdata[15:0] : '0;
      end
      HI: begin
        sram_addr   = {r_idx, 1'b1};
        sram_we_n   = ~r_is_wr;
        sram_dq_oe  = r_is_wr;
        sram_dq_out = r_is_wr ? r_wdata[31:16] : '0;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM holding data memory. It accepts one 32-bit load or store per request and splits it into two half-word SRAM accesses, low half first, each held for a programmable number of cycles. While an access is in progress it drives `ready` low, and the top level uses `~ready` to freeze the whole pipeline. When `ready` rises, load data is on `read_data` for the WB path.

## Interface
- `ACCESS_CYCLES`, default 2: cycles each half-word access is held on the SRAM bus; legal range 1..15.
- `DATA_BASE`, default 1024: byte address that maps to SRAM half-word 0.
- `SRAM_ADDR_W`, default 18: SRAM half-word address width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rd_en` input 1: load request from the MEM stage.
- `wr_en` input 1: store request from the MEM stage.
- `address` input 32: byte address, which is the ALU result.
- `write_data` input 32: store data (val_rm).
- `read_data` output 32: load result, registered.
- `ready` output 1: high when the stage may advance.
- `err` output 1: address error pulse; exists only with `SRAM_ERR_CHECK_EN`.
- `sram_addr` output SRAM_ADDR_W: SRAM half-word address.
- `sram_dq_out` output 16: SRAM write data.
- `sram_dq_in` input 16: SRAM read data.
- `sram_dq_oe` output 1: data bus drive enable; the top level builds the tristate from it.
- `sram_we_n` output 1: SRAM write enable, active-low.

## Operation
- Request = `rd_en | wr_en`. If both are high, the request is a write.
- Offset: `off = address - DATA_BASE`.
- Word index: `off[SRAM_ADDR_W:2]`.
- `sram_addr` = `{word index, 1'b0}` in LO, `{word index, 1'b1}` in HI.
- Address and `write_data` are sampled into internal registers on the IDLE→LO transition. They are ignored afterwards.
- States and transitions:
  - IDLE: on a request, go to LO and load the wait counter with ACCESS_CYCLES-1.
  - LO: when the counter reaches 0, go to HI and reload it.
  - HI: when the counter reaches 0, go to DONE.
  - DONE: always go to IDLE.
- Write transfers:
  - `sram_dq_oe`=1 and `sram_we_n`=0 for every LO and HI cycle.
  - `sram_dq_out` = `write_data[15:0]` in LO and `write_data[31:16]` in HI.
- Read transfers:
  - `sram_dq_oe`=0 and `sram_we_n`=1 throughout.
  - `read_data[15:0]` captures `sram_dq_in` on the last LO cycle.
  - `read_data[31:16]` captures it on the last HI cycle.
  - On a write, `read_data` holds its previous value.
- `ready` = (state==IDLE & no request) | (state==DONE). It is combinational from the state and the request inputs.
- A request held high after DONE counts as a new request. The frozen pipeline guarantees the request has changed by then.
- Outside LO/HI: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.

## Timing
- Reset values: state IDLE, `read_data`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0, `err`=0.
- `ready` after reset is 1 if no request is present.
- Reset asserted mid-access forces IDLE immediately. A partial write may leave the SRAM half-updated; that is accepted.
- Latency: the request is seen in IDLE at cycle 0.
  - LO occupies cycles 1..N and HI occupies cycles N+1..2N, with N=ACCESS_CYCLES.
  - DONE is cycle 2N+1, with `ready`=1 and `read_data` valid.
  - Total freeze is 2N+1 cycles; for N=2 that is 5.
- `ready` drops in the same cycle a request appears, so there is no dead cycle before the freeze.

## Configuration
- Macro: `SRAM_ERR_CHECK_EN`.
- Defined: a request is an error if `address < DATA_BASE`, `address[1:0] != 0`, or the word index overflows SRAM_ADDR_W-1 bits.
  - On an error, IDLE goes to DONE directly with no SRAM activity.
  - `err`=1 for that DONE cycle only. `read_data` is unchanged and `ready` rises after 1 cycle.
- Undefined: no checks. `address[1:0]` is ignored, offsets wrap modulo the SRAM size, and the `err` port is absent.

## Structure
- Package `arm_mem_pkg`: state enum (IDLE, LO, HI, DONE), `DATA_BASE_DEFAULT`=1024, `SRAM_HALF_W`=16.
- Sub-module `sram_wait_counter`: a 4-bit loadable down-counter with load and enable inputs and a zero flag. It is shared by the LO and HI states.

## Test plan
- Store: `wr_en`=1, `address`=1024, `write_data`=0xDEADBEEF, N=2.
  - Cycles 1-2: `sram_addr`=0, `dq_out`=0xBEEF, `we_n`=0.
  - Cycles 3-4: `sram_addr`=1, `dq_out`=0xDEAD.
  - Cycle 5: `ready`=1.
- Load from `address`=1028 with the SRAM model holding 0x1234 at half-word 2 and 0xABCD at half-word 3.
  - `sram_addr` sequence is 2,2,3,3.
  - `read_data`=0xABCD1234 in DONE; `we_n` stays 1.
- Idle with no request: `ready`=1 and all SRAM outputs inactive for 10 cycles.
- `rd_en` and `wr_en` both high at 1032: behaves as a write to half-words 4/5.
- Reset pulled low during the HI state: the next edge is not needed; state is IDLE, `we_n`=1, `read_data`=0 immediately. A fresh load afterwards completes in 5 cycles.
- With `SRAM_ERR_CHECK_EN`:
  - `rd_en` at `address`=1026 gives `err`=1 and `ready`=1 at cycle 1, with no `we_n` or address activity.
  - `address`=512 behaves the same way.
